// File: rtl/ysyx_issue_ctl_pkg.sv
// ysyx_issue_ctl_pkg: shared issue-control types and defaults
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_issue_ctl_pkg;
    localparam int MAX_INFLIGHT_DEF = 4;
    typedef enum logic [1:0] {RUN, DRAIN, SERIAL} issue_state_e;
endpackage

// File: rtl/ysyx_scoreboard.sv
// ysyx_scoreboard: per-register busy bits with set/clear, flush and three read ports
module ysyx_scoreboard #(
    parameter int REG_LEN = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               set_en,
    input  logic [REG_LEN-1:0] set_idx,
    input  logic               clr_en,
    input  logic [REG_LEN-1:0] clr_idx,
    input  logic [REG_LEN-1:0] rs1,
    input  logic [REG_LEN-1:0] rs2,
    input  logic [REG_LEN-1:0] rd,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic               rd_busy
);
    localparam int N = 2 ** REG_LEN;
    logic [N-1:0] busy, set_mask, clr_mask;
    assign set_mask = set_en ? N'(1) << set_idx : '0;
    assign clr_mask = clr_en ? N'(1) << clr_idx : '0;
    // x0 is hard-wired never busy
    always_ff @(posedge clock)
        busy <= (reset || flush) ? '0 : ((busy & ~clr_mask) | set_mask) & ~N'(1);
    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
    assign rd_busy  = busy[rd];
endmodule

// File: rtl/ysyx_issue_ctl.sv
// ysyx_issue_ctl: in-order issue gate with scoreboard hazards, inflight cap and system-uop serialization
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

module ysyx_issue_ctl
    import ysyx_issue_ctl_pkg::*;
#(
    parameter int REG_LEN      = `YSYX_REG_LEN,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_LEN-1:0]            in_rs1,
    input  logic                          in_rs1_use,
    input  logic [REG_LEN-1:0]            in_rs2,
    input  logic                          in_rs2_use,
    input  logic [REG_LEN-1:0]            in_rd,
    input  logic                          in_rd_wen,
    input  logic                          in_system,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    input  logic                          commit_valid,
    input  logic [REG_LEN-1:0]            commit_rd,
    input  logic                          commit_wen,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          stall
);
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
    issue_state_e state, state_n;
    logic [CW-1:0] inflight_n;
    logic rs1_busy, rs2_busy, rd_busy, hazard, permit, fire, commit_ok;

    ysyx_scoreboard #(.REG_LEN(REG_LEN)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .set_en   (fire & in_rd_wen),
        .set_idx  (in_rd),
        .clr_en   (commit_valid & commit_wen),
        .clr_idx  (commit_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign hazard      = (in_rs1_use & rs1_busy) | (in_rs2_use & rs2_busy) | (in_rd_wen & rd_busy);
    assign permit      = state == RUN && (!in_system || inflight == '0);
    assign issue_valid = !reset && in_valid && !hazard && !flush && inflight < MAX_CNT && permit;
    assign in_ready    = issue_valid & issue_ready;
    assign stall       = !reset && in_valid && !issue_valid;
    assign fire        = in_ready;
    assign commit_ok   = commit_valid && inflight != '0;

    always_comb begin
        inflight_n = (fire && !commit_ok) ? inflight + 1'b1 :
                     (commit_ok && !fire) ? inflight - 1'b1 : inflight;
        state_n = state;
        case (state)
            RUN:     state_n = (fire && in_system) ? SERIAL :
                               (in_valid && in_system && inflight != '0) ? DRAIN : RUN;
            DRAIN:   state_n = inflight == '0 ? RUN : DRAIN;
            SERIAL:  state_n = (commit_ok && inflight == CW'(1)) ? RUN : SERIAL;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state    <= RUN;
            inflight <= '0;
        end else begin
            state    <= state_n;
            inflight <= inflight_n;
        end
    end
endmodule
